// File: rtl/edge_pkg.sv
// Shared constants and FSM encoding for the Sobel edge binarizer.
package edge_pkg;
    localparam int PIX_W = 8;
    localparam logic [PIX_W-1:0] EDGE_ON  = 8'hFF;
    localparam logic [PIX_W-1:0] EDGE_OFF = 8'h00;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;
endpackage

// File: rtl/edge_luma.sv
// Stage 1: weighted R+2G+B luma approximation, with valid and pixel position carried alongside.
module edge_luma
    import edge_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] red,
    input  logic [PIX_W-1:0] green,
    input  logic [PIX_W-1:0] blue,
    input  logic             valid,
    input  logic [CNT_W-1:0] col,
    input  logic [CNT_W-1:0] row,
    output logic [PIX_W-1:0] luma,
    output logic             luma_valid,
    output logic [CNT_W-1:0] luma_col,
    output logic [CNT_W-1:0] luma_row
);
    // Two extra bits hold the worst case 4*255 without overflow.
    logic [PIX_W+1:0] sum_next;
    logic [PIX_W-1:0] luma_reg;
    logic             valid_reg;
    logic [CNT_W-1:0] col_reg;
    logic [CNT_W-1:0] row_reg;

    assign sum_next = {2'b00, red} + {1'b0, green, 1'b0} + {2'b00, blue};

    always_ff @(posedge clk) begin
        if (!rst) begin
            luma_reg  <= '0;
            valid_reg <= 1'b0;
            col_reg   <= '0;
            row_reg   <= '0;
        end else begin
            valid_reg <= valid;
            if (valid) begin
                luma_reg <= sum_next[PIX_W+1:2];
                col_reg  <= col;
                row_reg  <= row;
            end
        end
    end

    assign luma       = luma_reg;
    assign luma_valid = valid_reg;
    assign luma_col   = col_reg;
    assign luma_row   = row_reg;
endmodule

// File: rtl/edge_binarize.sv
// Binary edge map from a Sobel RGB stream: luma threshold, border blanking, position tracking,
// end-of-frame pulse and saturating per-frame edge count. Two-cycle latency, no backpressure.
module edge_binarize
    import edge_pkg::*;
#(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int CNT_W  = 16,
    parameter int ECNT_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        sob_red_i,
    input  logic [7:0]        sob_green_i,
    input  logic [7:0]        sob_blue_i,
    input  logic              sob_done_i,
    input  logic [7:0]        thresh_i,
    output logic [7:0]        bin_red_o,
    output logic [7:0]        bin_green_o,
    output logic [7:0]        bin_blue_o,
    output logic              bin_done_o,
    output logic [CNT_W-1:0]  col_o,
    output logic [CNT_W-1:0]  row_o,
    output logic              frame_done_o,
    output logic [ECNT_W-1:0] edge_cnt_o
);
    localparam logic [CNT_W-1:0]  COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0]  ROW_LAST = CNT_W'(IMG_H - 1);
    localparam logic [ECNT_W-1:0] ACC_MAX  = '1;

    state_t            state_reg;
    logic [CNT_W-1:0]  col_reg;
    logic [CNT_W-1:0]  row_reg;
    logic [PIX_W-1:0]  thr_reg;
    logic              in_last;

    logic [PIX_W-1:0]  luma_s1;
    logic              valid_s1;
    logic [CNT_W-1:0]  col_s1;
    logic [CNT_W-1:0]  row_s1;

    logic              border_s1;
    logic              last_s1;
    logic              is_edge;
    logic [ECNT_W-1:0] acc_reg;
    logic [ECNT_W-1:0] acc_next;

    logic [PIX_W-1:0]  bin_reg;
    logic              bin_done_reg;
    logic [CNT_W-1:0]  col_out_reg;
    logic [CNT_W-1:0]  row_out_reg;
    logic              frame_done_reg;
    logic [ECNT_W-1:0] edge_cnt_reg;

    assign in_last = (col_reg == COL_LAST) && (row_reg == ROW_LAST);

    // Input-side position counters and frame FSM; threshold is sampled once per frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            col_reg   <= '0;
            row_reg   <= '0;
            thr_reg   <= '0;
        end else if (sob_done_i) begin
            if (col_reg == COL_LAST) begin
                col_reg <= '0;
                row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_ACTIVE;
                    thr_reg   <= thresh_i;
                end
                ST_ACTIVE: begin
                    if (in_last) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    edge_luma #(
        .CNT_W(CNT_W)
    ) u_luma (
        .clk       (clk),
        .rst       (rst),
        .red       (sob_red_i),
        .green     (sob_green_i),
        .blue      (sob_blue_i),
        .valid     (sob_done_i),
        .col       (col_reg),
        .row       (row_reg),
        .luma      (luma_s1),
        .luma_valid(valid_s1),
        .luma_col  (col_s1),
        .luma_row  (row_s1)
    );

    // The last row is all border, so a re-latched threshold never affects the previous frame's tail.
    always_comb begin
        border_s1 = (col_s1 == '0) || (col_s1 == COL_LAST) || (row_s1 == '0) || (row_s1 == ROW_LAST);
        last_s1   = (col_s1 == COL_LAST) && (row_s1 == ROW_LAST);
        is_edge   = valid_s1 && (luma_s1 >= thr_reg) && !border_s1;
        acc_next  = acc_reg;
        if (is_edge && (acc_reg != ACC_MAX)) begin
            acc_next = acc_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bin_reg        <= EDGE_OFF;
            bin_done_reg   <= 1'b0;
            col_out_reg    <= '0;
            row_out_reg    <= '0;
            frame_done_reg <= 1'b0;
            edge_cnt_reg   <= '0;
            acc_reg        <= '0;
        end else begin
            bin_done_reg   <= valid_s1;
            frame_done_reg <= valid_s1 && last_s1;
            if (valid_s1) begin
                bin_reg     <= is_edge ? EDGE_ON : EDGE_OFF;
                col_out_reg <= col_s1;
                row_out_reg <= row_s1;
                if (last_s1) begin
                    edge_cnt_reg <= acc_next;
                    acc_reg      <= '0;
                end else begin
                    acc_reg <= acc_next;
                end
            end
        end
    end

    assign bin_red_o    = bin_reg;
    assign bin_green_o  = bin_reg;
    assign bin_blue_o   = bin_reg;
    assign bin_done_o   = bin_done_reg;
    assign col_o        = col_out_reg;
    assign row_o        = row_out_reg;
    assign frame_done_o = frame_done_reg;
    assign edge_cnt_o   = edge_cnt_reg;
endmodule

// File: tb/tb_edge_binarize.sv
// Directed and randomized bench for edge_binarize against a per-pixel reference model.
module tb_edge_binarize;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 4;
    localparam int CNT_W  = 16;
    localparam int ECNT_W = 2;
    localparam int FRAME  = IMG_W * IMG_H;
    localparam int SAT    = (1 << ECNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        sob_red_i = '0;
    logic [7:0]        sob_green_i = '0;
    logic [7:0]        sob_blue_i = '0;
    logic              sob_done_i = 1'b0;
    logic [7:0]        thresh_i = '0;
    logic [7:0]        bin_red_o;
    logic [7:0]        bin_green_o;
    logic [7:0]        bin_blue_o;
    logic              bin_done_o;
    logic [CNT_W-1:0]  col_o;
    logic [CNT_W-1:0]  row_o;
    logic              frame_done_o;
    logic [ECNT_W-1:0] edge_cnt_o;

    int checks = 0;
    int failures = 0;

    // Reference model: position within frame, frame threshold, running edge total.
    int m_col, m_row, m_thr, m_acc;
    bit m_active;
    // Expected DUT outputs after the next clock edge.
    bit e_valid, e_fd;
    int e_bin, e_col, e_row, e_cnt;

    edge_binarize #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CNT_W (CNT_W),
        .ECNT_W(ECNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sob_red_i   (sob_red_i),
        .sob_green_i (sob_green_i),
        .sob_blue_i  (sob_blue_i),
        .sob_done_i  (sob_done_i),
        .thresh_i    (thresh_i),
        .bin_red_o   (bin_red_o),
        .bin_green_o (bin_green_o),
        .bin_blue_o  (bin_blue_o),
        .bin_done_o  (bin_done_o),
        .col_o       (col_o),
        .row_o       (row_o),
        .frame_done_o(frame_done_o),
        .edge_cnt_o  (edge_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_col = 0; m_row = 0; m_thr = 0; m_acc = 0; m_active = 0;
        e_valid = 0; e_fd = 0; e_bin = 0; e_col = 0; e_row = 0; e_cnt = 0;
    endtask

    // One clock: drive inputs, check outputs produced by the previous cycle's pixel, advance model.
    task automatic step(input bit rn, input bit v, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic [7:0] th);
        int  luma;
        bit  hit, last;
        rst = rn; sob_done_i = v; sob_red_i = r; sob_green_i = g; sob_blue_i = b; thresh_i = th;
        if (!rn) model_reset();
        @(posedge clk);
        #1;
        chk("bin_done", 32'(bin_done_o), 32'(e_valid));
        chk("bin_red", 32'(bin_red_o), 32'(e_bin));
        chk("bin_green", 32'(bin_green_o), 32'(e_bin));
        chk("bin_blue", 32'(bin_blue_o), 32'(e_bin));
        chk("col", 32'(col_o), 32'(e_col));
        chk("row", 32'(row_o), 32'(e_row));
        chk("frame_done", 32'(frame_done_o), 32'(e_fd));
        chk("edge_cnt", 32'(edge_cnt_o), 32'(e_cnt));
        if (bin_done_o)
            $display("pix col=%0d row=%0d bin=%02h fd=%0b cnt=%0d", col_o, row_o, bin_red_o,
                     frame_done_o, edge_cnt_o);
        e_valid = 0;
        e_fd = 0;
        if (rn && v) begin
            if (!m_active) begin
                m_thr = int'(th);
                m_active = 1;
            end
            luma = (int'(r) + 2 * int'(g) + int'(b)) / 4;
            hit = (luma >= m_thr) && m_col != 0 && m_col != IMG_W - 1 &&
                  m_row != 0 && m_row != IMG_H - 1;
            last = (m_col == IMG_W - 1) && (m_row == IMG_H - 1);
            e_valid = 1;
            e_bin = hit ? 8'hFF : 8'h00;
            e_col = m_col;
            e_row = m_row;
            if (hit && m_acc < SAT) m_acc++;
            if (last) begin
                e_fd = 1;
                e_cnt = m_acc;
                m_acc = 0;
                m_active = 0;
            end
            m_col++;
            if (m_col == IMG_W) begin
                m_col = 0;
                m_row = (m_row + 1) % IMG_H;
            end
        end
    endtask

    initial begin
        logic [7:0] th;
        model_reset();
        // Reset with valid held high: nothing must come out.
        repeat (5) step(0, 1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        // Uniform mid-grey frame, continuous valid; interior edges saturate the count.
        for (int i = 0; i < FRAME; i++) step(1, 1, 8'h80, 8'h80, 8'h80, 8'h40);
        // Threshold equality, one above, and full-scale luma without overflow; back to back.
        for (int i = 0; i < FRAME; i++) step(1, 1, 8'h40, 8'h40, 8'h40, 8'h40);
        for (int i = 0; i < FRAME; i++) step(1, 1, 8'h40, 8'h40, 8'h40, 8'h41);
        for (int i = 0; i < FRAME; i++) step(1, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        step(1, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        // 1-0-0 gap pattern with threshold raised mid-frame; next frame must see the new one.
        for (int i = 0; i < FRAME; i++) begin
            th = (i < 3) ? 8'h40 : 8'hFF;
            step(1, 1, 8'($urandom), 8'($urandom), 8'($urandom), th);
            step(1, 0, 8'($urandom), 8'($urandom), 8'($urandom), th);
            step(1, 0, 8'($urandom), 8'($urandom), 8'($urandom), th);
        end
        for (int i = 0; i < FRAME; i++) step(1, 1, 8'hC0, 8'hC0, 8'hC0, 8'hFF);
        // Reset after 7 pixels of a frame, then a fresh full frame.
        for (int i = 0; i < 7; i++) step(1, 1, 8'hFF, 8'hFF, 8'hFF, 8'h00);
        step(0, 1, 8'hFF, 8'hFF, 8'hFF, 8'h00);
        step(0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < FRAME; i++) step(1, 1, 8'($urandom), 8'($urandom), 8'($urandom), 8'h60);
        // Random frames with random gaps and per-cycle threshold noise.
        for (int f = 0; f < 4; f++) begin
            int n = 0;
            while (n < FRAME) begin
                if ($urandom_range(0, 3) == 0) begin
                    step(1, 0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                end else begin
                    step(1, 1, 8'($urandom), 8'($urandom), 8'($urandom),
                         8'($urandom_range(0, 160)));
                    n++;
                end
            end
        end
        repeat (3) step(1, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
